// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: writeback source select
// and load funct3 encodings.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_extend.sv
// Load data alignment and sign/zero extension from a raw memory word.
// Flags misaligned halfword/word accesses and unknown funct3 codes.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            err
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{offset, 3'b000} +: 8];
    assign h = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){b[7]}}, b};
            F3_LBU: data = {{(XLEN-8){1'b0}}, b};
            F3_LH: begin
                data = {{(XLEN-16){h[15]}}, h};
                err  = offset[0];
            end
            F3_LHU: begin
                data = {{(XLEN-16){1'b0}}, h};
                err  = offset[0];
            end
            F3_LW: begin
                data = rdata;
                err  = |offset;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB register, load wait with back-pressure,
// writeback source select, register file write port and retire counter.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic             mem_regWrite,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wbSel,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_aluResult,
    input  logic [XLEN-1:0]  mem_pcPlus4,
    input  logic             flush,
    input  logic             dmem_rvalid,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             stall,
    output logic             regWrite,
    output logic [4:0]       writeReg,
    output logic [XLEN-1:0]  writeData,
    output logic             load_err,
    output logic [CNT_W-1:0] instret
);

    logic            wb_valid;
    logic            wb_regWrite;
    logic [4:0]      wb_rd;
    wb_sel_e         wb_sel;
    logic [2:0]      wb_funct3;
    logic [XLEN-1:0] wb_alu;
    logic [XLEN-1:0] wb_pc4;

    logic            is_load;
    logic            done;
    logic            ld_err;
    logic            bad_load;
    logic [XLEN-1:0] ld_data;

    load_extend #(.XLEN(XLEN)) u_ext (
        .rdata  (dmem_rdata),
        .offset (wb_alu[1:0]),
        .funct3 (wb_funct3),
        .data   (ld_data),
        .err    (ld_err)
    );

    assign is_load  = (wb_sel == WB_LOAD);
    assign stall    = wb_valid & is_load & ~dmem_rvalid & ~flush;
    assign done     = wb_valid & (~is_load | dmem_rvalid) & ~flush;
    assign bad_load = is_load & ld_err;

    assign regWrite = done & wb_regWrite & (wb_rd != 5'd0)
                    & ~bad_load & (wb_sel != WB_RSVD);

    // Idle port is zeroed so a regfile bypass never matches a stale rd
    always_comb begin
        writeReg  = '0;
        writeData = '0;
        if (regWrite) begin
            writeReg = wb_rd;
            case (wb_sel)
                WB_ALU:  writeData = wb_alu;
                WB_LOAD: writeData = ld_data;
                WB_PC4:  writeData = wb_pc4;
                default: writeData = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_regWrite <= 1'b0;
            wb_rd       <= '0;
            wb_sel      <= WB_ALU;
            wb_funct3   <= '0;
            wb_alu      <= '0;
            wb_pc4      <= '0;
        end else if (flush) begin
            wb_valid    <= 1'b0;
        end else if (!stall) begin
            wb_valid    <= mem_valid;
            wb_regWrite <= mem_regWrite;
            wb_rd       <= mem_rd;
            wb_sel      <= wb_sel_e'(mem_wbSel);
            wb_funct3   <= mem_funct3;
            wb_alu      <= mem_aluResult;
            wb_pc4      <= mem_pcPlus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_err <= 1'b0;
            instret  <= '0;
        end else if (done) begin
            instret <= instret + CNT_W'(1);
            if (bad_load)
                load_err <= 1'b1;
        end
    end

endmodule
